mux_rr_stream: RTL and testbench
================================

# mux_rr_stream

Parametrised N-channel, W-bit registered stream multiplexer: the successor to the 16-bit 2:1 combinational mux. It selects one of `CHANNELS` valid/ready input streams per cycle by round-robin or fixed-priority arbitration, or by a forced static select. The chosen word goes into a single output register. It sits between multiple word producers (ALU results, memory read ports, I/O) and one shared consumer such as a register-file write port or a bus.

## Interface
Parameters:
- `WIDTH`, 16, data word width in bits (≥1).
- `CHANNELS`, 4, number of input streams (≥2).
- `MODE`, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `SELW`, derived `max(1, $clog2(CHANNELS))`, select width. Not overridable.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input `CHANNELS*WIDTH`: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid` input `CHANNELS`: per-channel word available.
- `in_ready` output `CHANNELS`: per-channel accept. One-hot or zero.
- `force_en` input 1: static-select override. Only channel `force_sel` is eligible.
- `force_sel` input `SELW`: forced channel index. Values ≥ `CHANNELS` make no channel eligible.
- `out_data` output `WIDTH`: registered selected word.
- `out_valid` output 1: output register holds a word.
- `out_ready` input 1: consumer accepts `out_data` this cycle.
- `out_sel` output `SELW`: index of the channel that supplied `out_data`.

## Operation
- Load enable: `load = !out_valid || out_ready`. Draining and refilling in the same cycle is allowed.
- Eligible set: `in_valid` masked to `force_sel` when `force_en=1`. Otherwise all of `in_valid`.
- Grant g, when `load=1` and the eligible set is non-empty:
  - MODE 0: first eligible index at or after `rr_ptr`, scanning upward and wrapping `CHANNELS-1 → 0`.
  - MODE 1: lowest eligible index.
  - `in_ready = 1<<g`, otherwise 0. `in_ready` is combinational from `in_valid`, `out_ready`, `out_valid`, `force_*`, and `rr_ptr`.
- On transfer (`in_valid[g] && in_ready[g]`):
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - MODE 0: `rr_ptr <= (g+1) mod CHANNELS`. MODE 1 and forced grants also update `rr_ptr`.
- Drain with no refill (`out_valid && out_ready` and no transfer): `out_valid <= 0`. `out_data` and `out_sel` hold their last value.
- Stall (`out_valid && !out_ready`): `in_ready=0`, and all registers hold.
- Non-power-of-two `CHANNELS`: wrap is an explicit compare, never bit truncation.

## Timing
- Reset values (cycle after `rst` sampled high): `out_valid=0`, `out_data=0`, `out_sel=0`, `rr_ptr=0`. `in_ready=0` while `rst=1`.
- Reset mid-transfer: the pending word is dropped and no input is acked in the reset cycle.
- Latency: input accepted at edge n, visible on `out_*` after edge n.
- Throughput: one word per cycle when `out_ready` is held at 1.
- Fairness, MODE 0: with all channels continuously valid, each channel is granted exactly once in any `CHANNELS` consecutive transfers.
- `force_en` changes take effect combinationally in the same cycle. They never corrupt a word already in the output register.

## Structure
- Shared package `mux_pkg`:
  - `MODE_RR=0` and `MODE_FIXED=1` constants.
  - `sel_width(n)` function returning `max(1,$clog2(n))`.
- Sub-module `rr_arbiter`, parametrised `CHANNELS` and `MODE`.
  - Inputs: `clk`, `rst`, `req`, `advance`.
  - Outputs: one-hot `grant`, binary `grant_idx`.
  - Owns `rr_ptr`.
- The top level holds the output register, the force masking, and the data mux.

## Test plan
- Reset: drive `rst=1` for 2 cycles with `in_valid=4'b1111`. Required: `in_ready=0`, `out_valid=0`, `out_data=0`, `out_sel=0`.
- Round-robin: `CHANNELS=4`, all valid, `in_data` channel i = `16'h00A0+i`, `out_ready=1`. Required: outputs `00A0, 00A1, 00A2, 00A3, 00A0` on consecutive cycles with `out_sel` 0, 1, 2, 3, 0.
- Fixed priority: `MODE=1`, `in_valid=4'b1010`. Required: channel 1 granted every cycle and channel 3 starved.
- Backpressure: fill the output register with `16'h1234`, then hold `out_ready=0` for 3 cycles. Required:
  - `out_data=16'h1234` is held and `in_ready=0`.
  - On release, the next word loads in the same cycle as the drain, with no bubble.
- Force: `force_en=1`, `force_sel=2`, `in_valid=4'b1011`. Required: no grant.
  - With `force_sel=2` and `in_valid[2]=1`: only channel 2 is granted.
  - With `force_sel=5` (SELW=2 cannot encode this; test with CHANNELS=3, `force_sel=3`): no grant.
- Reset mid-stream: assert `rst` while `out_valid=1`, `out_ready=0`. Required:
  - `out_valid=0` next cycle.
  - `rr_ptr` returns to 0, so the first post-reset grant goes to channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the round-robin stream mux.
//   MODE_RR / MODE_FIXED : arbitration mode encodings
//   sel_width(n)         : width of a binary channel index, never below 1
package mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_stream_arbiter.sv
// rr_arbiter: one-hot grant over a request vector.
//   clk, rst    : clock, synchronous active-high reset
//   req         : requests (already gated by the caller's load condition)
//   advance     : a grant was consumed this cycle; move the pointer past it
//   grant       : one-hot grant, zero when req is zero
//   grant_idx   : binary index of the granted request
// MODE_RR searches from rr_ptr upward with wrap; MODE_FIXED picks the lowest.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int MODE     = MODE_RR,
    localparam int SELW     = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant,
    output logic [SELW-1:0]     grant_idx
);

    logic [SELW-1:0] rr_ptr;
    logic            found;

    // Two passes: first the requests at or above the pointer, then all of
    // them; the second pass covers the wrap from the top back to channel 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (MODE == MODE_RR) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!found && req[i] && i >= int'(rr_ptr)) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = SELW'(i);
            end
        end
    end

    // Explicit compare for the wrap so non-power-of-two channel counts work.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-channel valid/ready stream mux into one output register.
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_valid    : CHANNELS packed input words and their valids
//   in_ready            : one-hot (or zero) accept back to the inputs
//   force_en/force_sel  : restrict eligibility to a single channel index
//   out_data/out_valid  : registered selected word
//   out_ready           : consumer accept
//   out_sel             : channel that supplied out_data
module mux_rr_stream
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = MODE_RR,
    localparam int SELW     = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SELW-1:0]           force_sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SELW-1:0]           out_sel
);

    logic                load;
    logic [CHANNELS-1:0] force_mask;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] grant;
    logic [SELW-1:0]     grant_idx;
    logic                xfer;
    logic [WIDTH-1:0]    sel_word;

    assign load = !out_valid || out_ready;

    // Out-of-range force_sel matches no bit, so nothing is eligible.
    always_comb begin
        force_mask = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(force_sel) == i) force_mask[i] = 1'b1;
        end
    end

    // Gating requests with load and reset means any grant is a transfer.
    assign req  = (force_en ? (in_valid & force_mask) : in_valid)
                & {CHANNELS{load && !rst}};
    assign xfer = |grant;
    assign in_ready = grant;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .MODE     (MODE)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) sel_word = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_word;
            out_sel   <= grant_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
module tb_mux_rr_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_ready = 1'b0;
    logic        force_en = 1'b0;

    logic [63:0] in_data4 = '0;
    logic [3:0]  in_valid4 = '0;
    logic [1:0]  force_sel4 = '0;
    logic [47:0] in_data3 = '0;
    logic [2:0]  in_valid3 = '0;
    logic [1:0]  force_sel3 = '0;

    logic [3:0]  rdy_rr, rdy_fx;
    logic [2:0]  rdy_c3;
    logic [15:0] od_rr, od_fx, od_c3;
    logic        ov_rr, ov_fx, ov_c3;
    logic [1:0]  os_rr, os_fx, os_c3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_rr_stream #(.WIDTH(16), .CHANNELS(4), .MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(rdy_rr), .force_en(force_en), .force_sel(force_sel4),
        .out_data(od_rr), .out_valid(ov_rr), .out_ready(out_ready), .out_sel(os_rr));

    mux_rr_stream #(.WIDTH(16), .CHANNELS(4), .MODE(1)) dut_fx (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(rdy_fx), .force_en(force_en), .force_sel(force_sel4),
        .out_data(od_fx), .out_valid(ov_fx), .out_ready(out_ready), .out_sel(os_fx));

    mux_rr_stream #(.WIDTH(16), .CHANNELS(3), .MODE(0)) dut_c3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(rdy_c3), .force_en(force_en), .force_sel(force_sel3),
        .out_data(od_c3), .out_valid(ov_c3), .out_ready(out_ready), .out_sel(os_c3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: output register contents plus the next channel to try.
    typedef struct {
        bit          v;
        logic [15:0] d;
        int          s;
        int          p;
    } mst_t;

    mst_t st_rr, st_fx, st_c3;
    logic [3:0] seen_rr, seen_c3;

    // Which channel gets the word this cycle, -1 for none.
    function automatic int pick(input int c, input int mode, input mst_t s,
                                input int vmask, input int fs);
        int el;
        if (rst) return -1;
        if (s.v && !out_ready) return -1;
        el = force_en ? ((fs < c) ? (vmask & (1 << fs)) : 0) : vmask;
        for (int k = 0; k < c; k++) begin
            int idx;
            idx = (mode == 1) ? k : (s.p + k) % c;
            if ((el >> idx) & 1) return idx;
        end
        return -1;
    endfunction

    function automatic mst_t nxt(input mst_t s, input int g, input logic [15:0] w, input int c);
        mst_t n;
        n = s;
        if (rst) begin
            n.v = 0; n.d = '0; n.s = 0; n.p = 0;
        end else if (g >= 0) begin
            n.v = 1; n.d = w; n.s = g; n.p = (g + 1) % c;
        end else if (s.v && out_ready) begin
            n.v = 0;
        end
        return n;
    endfunction

    // One clock: check in_ready against the model before the edge, then
    // the registered outputs after it.
    task automatic step();
        int g0, g1, g2;
        mst_t n0, n1, n2;
        logic [15:0] w0, w1, w2;
        #1;
        g0 = pick(4, 0, st_rr, int'(in_valid4), int'(force_sel4));
        g1 = pick(4, 1, st_fx, int'(in_valid4), int'(force_sel4));
        g2 = pick(3, 0, st_c3, int'(in_valid3), int'(force_sel3));
        chk("rdy_rr", 32'(rdy_rr), (g0 < 0) ? 0 : (1 << g0));
        chk("rdy_fx", 32'(rdy_fx), (g1 < 0) ? 0 : (1 << g1));
        chk("rdy_c3", 32'(rdy_c3), (g2 < 0) ? 0 : (1 << g2));
        seen_rr = rdy_rr;
        seen_c3 = {1'b0, rdy_c3};
        w0 = (g0 >= 0) ? in_data4[g0*16 +: 16] : 16'h0;
        w1 = (g1 >= 0) ? in_data4[g1*16 +: 16] : 16'h0;
        w2 = (g2 >= 0) ? in_data3[g2*16 +: 16] : 16'h0;
        n0 = nxt(st_rr, g0, w0, 4);
        n1 = nxt(st_fx, g1, w1, 4);
        n2 = nxt(st_c3, g2, w2, 3);
        @(posedge clk);
        @(negedge clk);
        st_rr = n0; st_fx = n1; st_c3 = n2;
        chk("ov_rr", 32'(ov_rr), 32'(st_rr.v));
        chk("od_rr", 32'(od_rr), 32'(st_rr.d));
        chk("os_rr", 32'(os_rr), st_rr.s);
        chk("ov_fx", 32'(ov_fx), 32'(st_fx.v));
        chk("od_fx", 32'(od_fx), 32'(st_fx.d));
        chk("os_fx", 32'(os_fx), st_fx.s);
        chk("ov_c3", 32'(ov_c3), 32'(st_c3.v));
        chk("od_c3", 32'(od_c3), 32'(st_c3.d));
        chk("os_c3", 32'(os_c3), st_c3.s);
    endtask

    initial begin
        logic [15:0] rr_exp [5];
        st_rr = '{0, 16'h0, 0, 0};
        st_fx = st_rr;
        st_c3 = st_rr;
        rr_exp = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A0};
        @(negedge clk);

        // Reset with every input valid
        rst = 1; in_valid4 = 4'b1111; in_valid3 = 3'b111;
        for (int i = 0; i < 4; i++) in_data4[i*16 +: 16] = 16'h00A0 + 16'(i);
        for (int i = 0; i < 3; i++) in_data3[i*16 +: 16] = 16'h00B0 + 16'(i);
        repeat (2) begin
            step();
            chk("rst_in_ready", 32'(seen_rr), 0);
        end
        chk("rst_out_valid", 32'(ov_rr), 0);
        chk("rst_out_data", 32'(od_rr), 0);
        chk("rst_out_sel", 32'(os_rr), 0);

        // Round-robin over all four channels
        rst = 0; out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_seq_data", 32'(od_rr), 32'(rr_exp[i]));
            chk("rr_seq_sel", 32'(os_rr), i % 4);
        end

        // Fixed priority: channel 1 always beats channel 3
        in_valid4 = 4'b1010;
        repeat (4) begin
            step();
            chk("fx_sel", 32'(os_fx), 1);
        end

        // Backpressure: load 1234 then stall three cycles
        in_valid4 = 4'b0001; in_data4[15:0] = 16'h1234;
        step();
        chk("bp_load", 32'(od_rr), 32'h1234);
        out_ready = 0; in_valid4 = 4'b1111; in_data4[15:0] = 16'h5678;
        repeat (3) begin
            step();
            chk("bp_hold", 32'(od_rr), 32'h1234);
            chk("bp_in_ready", 32'(seen_rr), 0);
        end
        out_ready = 1;
        step();
        chk("bp_no_bubble_v", 32'(ov_rr), 1);
        chk("bp_no_bubble_sel", 32'(os_rr), 1);

        // Force select
        force_en = 1; force_sel4 = 2; in_valid4 = 4'b1011;
        force_sel3 = 2'd3; in_valid3 = 3'b111;
        step();
        chk("force_none", 32'(seen_rr), 0);
        chk("force_oob_c3", 32'(seen_c3), 0);
        in_valid4 = 4'b1111;
        repeat (2) begin
            step();
            chk("force_ch2", 32'(seen_rr), 32'h4);
        end

        // Reset while stalled on a full register
        force_en = 0; out_ready = 1;
        step();
        out_ready = 0;
        step();
        chk("mid_full", 32'(ov_rr), 1);
        rst = 1;
        step();
        chk("mid_rst_ack", 32'(seen_rr), 0);
        chk("mid_rst_valid", 32'(ov_rr), 0);
        rst = 0; out_ready = 1;
        step();
        chk("post_rst_sel", 32'(os_rr), 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            force_en   = ($urandom_range(0, 4) == 0);
            force_sel4 = 2'($urandom_range(0, 3));
            force_sel3 = 2'($urandom_range(0, 3));
            in_valid4  = 4'($urandom);
            in_valid3  = 3'($urandom);
            in_data4   = {$urandom, $urandom};
            in_data3   = {16'($urandom), $urandom};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
